// File: rtl/adc_frame_align_if.sv
// rtl/adc_frame_align_if.sv - control, status and ISERDES word bundle for adc_frame_align
interface adc_frame_align_if #(
    parameter int NLANES = 8,
    parameter int SERW   = 6,
    parameter int CNTW   = 8
);
    logic                       start;
    logic [SERW-1:0]            FR;
    logic [NLANES*SERW-1:0]     DIN;
    logic                       ins_clr;
    logic                       BS;
    logic                       busy;
    logic                       locked;
    logic                       fail;
    logic [$clog2(SERW)-1:0]    slips;
    logic [CNTW-1:0]            lost_cnt;
    logic [NLANES*CNTW-1:0]     ins_cnt;

    modport master (
        output start, FR, DIN, ins_clr,
        input  BS, busy, locked, fail, slips, lost_cnt, ins_cnt
    );

    modport slave (
        input  start, FR, DIN, ins_clr,
        output BS, busy, locked, fail, slips, lost_cnt, ins_cnt
    );
endinterface

// File: rtl/adc_frame_align.sv
// rtl/adc_frame_align.sv - bitslip training FSM with lock monitor and per-lane instability counters
module adc_frame_align #(
    parameter int              NLANES  = 8,
    parameter int              SERW    = 6,
    parameter logic [SERW-1:0] FRPAT   = 6'b111000,
    parameter int              SETTLE  = 4,
    parameter int              CHKLEN  = 16,
    parameter int              LOSSMAX = 3,
    parameter int              CNTW    = 8
) (
    input  logic               CLK,
    input  logic               reset,
    adc_frame_align_if.slave   bus
);
    localparam int SW = $clog2(SERW);
    localparam int MW = $clog2(CHKLEN + 1);
    localparam int LW = $clog2(LOSSMAX + 1);
    localparam int TW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SLIP, S_SETTLE, S_LOCKED, S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   slips_q, slips_d;
    logic [MW-1:0]   match_q, match_d;
    logic [LW-1:0]   miss_q, miss_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CNTW-1:0] lost_q, lost_d;
    logic            bs_q, bs_d;
    logic            busy_q, busy_d;
    logic            locked_q, locked_d;
    logic            fail_q, fail_d;
    logic            fr_match;

    assign fr_match = (bus.FR == FRPAT);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            slips_q  <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            timer_q  <= '0;
            lost_q   <= '0;
            bs_q     <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slips_q  <= slips_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            timer_q  <= timer_d;
            lost_q   <= lost_d;
            bs_q     <= bs_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slips_d = slips_q;
        match_d = match_q;
        miss_d  = miss_q;
        timer_d = timer_q;
        lost_d  = lost_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CHECK;
                    slips_d = '0;
                    match_d = '0;
                end
            end
            S_CHECK: begin
                if (fr_match) begin
                    if (match_q == MW'(CHKLEN - 1)) begin
                        state_d = S_LOCKED;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end else begin
                    match_d = '0;
                    // Every rotation has been tried once; give up rather than wrap.
                    if (slips_q == SW'(SERW - 1)) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_SLIP;
                    end
                end
            end
            S_SLIP: begin
                slips_d = slips_q + SW'(1);
                timer_d = TW'(SETTLE);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (timer_q <= TW'(1)) begin
                    state_d = S_CHECK;
                    match_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_LOCKED: begin
                if (bus.start) begin
                    state_d = S_CHECK;
                    slips_d = '0;
                    match_d = '0;
                    miss_d  = '0;
                end else if (!fr_match) begin
                    if (miss_q == LW'(LOSSMAX - 1)) begin
                        state_d = S_CHECK;
                        slips_d = '0;
                        match_d = '0;
                        miss_d  = '0;
                        if (!(&lost_q)) begin
                            lost_d = lost_q + CNTW'(1);
                        end
                    end else begin
                        miss_d = miss_q + LW'(1);
                    end
                end else begin
                    miss_d = '0;
                end
            end
            S_FAIL: begin
                if (bus.start) begin
                    state_d = S_CHECK;
                    slips_d = '0;
                    match_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Flags are decoded from the next state so they line up with the state register.
    always_comb begin
        bs_d     = (state_d == S_SLIP);
        busy_d   = (state_d == S_CHECK) || (state_d == S_SLIP) || (state_d == S_SETTLE);
        locked_d = (state_d == S_LOCKED);
        fail_d   = (state_d == S_FAIL);
    end

    assign bus.BS       = bs_q;
    assign bus.busy     = busy_q;
    assign bus.locked   = locked_q;
    assign bus.fail     = fail_q;
    assign bus.slips    = slips_q;
    assign bus.lost_cnt = lost_q;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        logic [SERW-1:0] prev_q;
        logic [CNTW-1:0] ins_q;

        always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
                prev_q <= '0;
                ins_q  <= '0;
            end else begin
                prev_q <= bus.DIN[SERW*i +: SERW];
                if (bus.ins_clr) begin
                    ins_q <= '0;
                end else if (locked_q && (bus.DIN[SERW*i +: SERW] != prev_q) && !(&ins_q)) begin
                    ins_q <= ins_q + CNTW'(1);
                end
            end
        end

        assign bus.ins_cnt[CNTW*i +: CNTW] = ins_q;
    end
endmodule
